// File: rtl/sel41_scanner_pkg.sv
// Shared definitions for the 4:1 time-division scanner and its matching de-selector.
// The channel codes and the idle level must agree on both ends of the shared line.
package sel41_scanner_pkg;

    localparam logic [1:0] CH0 = 2'b00;
    localparam logic [1:0] CH1 = 2'b01;
    localparam logic [1:0] CH2 = 2'b10;
    localparam logic [1:0] CH3 = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Every bit of an idle or unselected line sits at this level.
    localparam logic IDLE_BIT = 1'b1;

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return ch + 2'd1;
    endfunction

endpackage

// File: rtl/sel41_mux.sv
// Combinational 4:1 selector of W-bit channels, steered by a 2-bit channel code.
module sel41_mux
    import sel41_scanner_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] i_c0,
    input  logic [W-1:0] i_c1,
    input  logic [W-1:0] i_c2,
    input  logic [W-1:0] i_c3,
    input  logic [1:0]   i_sel,
    output logic [W-1:0] o_z
);

    always_comb begin
        o_z = i_c0;
        case (i_sel)
            CH0:     o_z = i_c0;
            CH1:     o_z = i_c1;
            CH2:     o_z = i_c2;
            CH3:     o_z = i_c3;
            default: o_z = i_c0;
        endcase
    end

endmodule

// File: rtl/sel41_scanner.sv
// Round-robin 4:1 time-division scanner: dwells DWELL cycles per channel and drives
// the registered channel code and data onto a line shared with a 1:4 de-selector.
module sel41_scanner
    import sel41_scanner_pkg::*;
#(
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iEn,
    input  logic         iRestart,
    input  logic [W-1:0] iC0,
    input  logic [W-1:0] iC1,
    input  logic [W-1:0] iC2,
    input  logic [W-1:0] iC3,
    output logic         oS1,
    output logic         oS0,
    output logic [W-1:0] oZ,
    output logic         oValid,
    output logic         oFrame
);

    localparam int             DCW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCW-1:0] DLAST  = DCW'(DWELL - 1);
    localparam logic [W-1:0]   IDLE_Z = {W{IDLE_BIT}};

    state_e         state_q, state_d;
    logic [1:0]     sel_q, sel_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [1:0]     s_q, s_d;
    logic [W-1:0]   z_q, z_d;
    logic           valid_q, valid_d;
    logic           frame_q, frame_d;

    logic [W-1:0]   mux_z;
    logic [DCW-1:0] dcnt_cur;
    logic           last;

    sel41_mux #(.W(W)) u_mux (
        .i_c0  (iC0),
        .i_c1  (iC1),
        .i_c2  (iC2),
        .i_c3  (iC3),
        .i_sel (sel_q),
        .o_z   (mux_z)
    );

    // The first scanning edge after IDLE always opens a fresh dwell.
    assign dcnt_cur = (state_q == ST_IDLE) ? '0 : dcnt_q;
    assign last     = (dcnt_cur == DLAST);

    always_comb begin
        state_d = iEn ? ST_SCAN : ST_IDLE;
        sel_d   = sel_q;
        dcnt_d  = dcnt_q;
        s_d     = s_q;
        z_d     = z_q;
        valid_d = 1'b0;
        frame_d = 1'b0;

        if (iRestart) begin
            sel_d  = CH0;
            dcnt_d = '0;
            s_d    = CH0;
            z_d    = iEn ? iC0 : IDLE_Z;
        end else if (iEn) begin
            s_d     = sel_q;
            z_d     = mux_z;
            valid_d = last;
            frame_d = last && (sel_q == CH3);
            if (last) begin
                dcnt_d = '0;
                sel_d  = next_ch(sel_q);
            end else begin
                dcnt_d = dcnt_cur + 1'b1;
            end
        end else begin
            // Disabled: the channel pointer and code hold, the partial dwell is dropped.
            z_d    = IDLE_Z;
            dcnt_d = '0;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            sel_q   <= CH0;
            dcnt_q  <= '0;
            s_q     <= CH0;
            z_q     <= IDLE_Z;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dcnt_q  <= dcnt_d;
            s_q     <= s_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
        end
    end

    assign oS1    = s_q[1];
    assign oS0    = s_q[0];
    assign oZ     = z_q;
    assign oValid = valid_q;
    assign oFrame = frame_q;

endmodule

// File: tb/tb_sel41_scanner.sv
// Directed bench for sel41_scanner: W=4/DWELL=2, W=1/DWELL=1 and a W=1/DWELL=3
// instance looped into a behavioural de-selector.
module tb_sel41_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: W=4, DWELL=2
    logic       rst_a, en_a, rs_a;
    logic [3:0] c0_a, c1_a, c2_a, c3_a;
    logic       s1_a, s0_a, v_a, f_a;
    logic [3:0] z_a;

    // Instance B: W=1, DWELL=1
    logic rst_b, en_b, rs_b;
    logic c0_b, c1_b, c2_b, c3_b;
    logic s1_b, s0_b, z_b, v_b, f_b;

    // Instance C: W=1, DWELL=3
    logic rst_c, en_c, rs_c;
    logic c0_c, c1_c, c2_c, c3_c;
    logic s1_c, s0_c, z_c, v_c, f_c;

    sel41_scanner #(.W(4), .DWELL(2)) u_a (
        .iClk(clk), .iRst(rst_a), .iEn(en_a), .iRestart(rs_a),
        .iC0(c0_a), .iC1(c1_a), .iC2(c2_a), .iC3(c3_a),
        .oS1(s1_a), .oS0(s0_a), .oZ(z_a), .oValid(v_a), .oFrame(f_a)
    );

    sel41_scanner #(.W(1), .DWELL(1)) u_b (
        .iClk(clk), .iRst(rst_b), .iEn(en_b), .iRestart(rs_b),
        .iC0(c0_b), .iC1(c1_b), .iC2(c2_b), .iC3(c3_b),
        .oS1(s1_b), .oS0(s0_b), .oZ(z_b), .oValid(v_b), .oFrame(f_b)
    );

    sel41_scanner #(.W(1), .DWELL(3)) u_c (
        .iClk(clk), .iRst(rst_c), .iEn(en_c), .iRestart(rs_c),
        .iC0(c0_c), .iC1(c1_c), .iC2(c2_c), .iC3(c3_c),
        .oS1(s1_c), .oS0(s0_c), .oZ(z_c), .oValid(v_c), .oFrame(f_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [1:0] s, input logic [3:0] z,
                           input logic v, input logic f);
        check({tag, ".s"}, 32'({s1_a, s0_a}), 32'(s));
        check({tag, ".z"}, 32'(z_a), 32'(z));
        check({tag, ".v"}, 32'(v_a), 32'(v));
        check({tag, ".f"}, 32'(f_a), 32'(f));
    endtask

    // Behavioural 1:4 de-selector fed from instance C's shared line.
    function automatic logic desel(input int j, input logic [1:0] s, input logic z);
        return (int'(s) == j) ? z : 1'b1;
    endfunction

    logic [3:0] tab_a [4];
    logic       tab_c [4];

    initial begin
        tab_a[0] = 4'hA; tab_a[1] = 4'h5; tab_a[2] = 4'hC; tab_a[3] = 4'h3;
        tab_c[0] = 1'b1; tab_c[1] = 1'b0; tab_c[2] = 1'b0; tab_c[3] = 1'b1;

        rst_a = 1'b1; en_a = 1'b0; rs_a = 1'b0;
        c0_a = 4'hA; c1_a = 4'h5; c2_a = 4'hC; c3_a = 4'h3;
        rst_b = 1'b1; en_b = 1'b0; rs_b = 1'b0;
        c0_b = 1'b0; c1_b = 1'b1; c2_b = 1'b0; c3_b = 1'b1;
        rst_c = 1'b1; en_c = 1'b0; rs_c = 1'b0;
        c0_c = tab_c[0]; c1_c = tab_c[1]; c2_c = tab_c[2]; c3_c = tab_c[3];

        #12;
        check_a("A.reset", 2'b00, 4'hF, 1'b0, 1'b0);
        check("C.reset.z", 32'(z_c), 32'h1);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a = 1'b1;

        // Plain scan: two full frames.
        for (int k = 0; k < 16; k++) begin
            tick();
            check_a($sformatf("A.scan[%0d]", k), 2'((k / 2) % 4), tab_a[(k / 2) % 4],
                    1'(k % 2), 1'(k % 8 == 7));
        end

        // Fresh start, then drop iEn for three cycles at the first channel-2 output.
        #2 rst_a = 1'b1;
        #1 check_a("A.rst2", 2'b00, 4'hF, 1'b0, 1'b0);
        rst_a = 1'b0;
        tick(); check_a("A.e1", 2'b00, 4'hA, 1'b0, 1'b0);
        tick(); check_a("A.e2", 2'b00, 4'hA, 1'b1, 1'b0);
        tick(); check_a("A.e3", 2'b01, 4'h5, 1'b0, 1'b0);
        tick(); check_a("A.e4", 2'b01, 4'h5, 1'b1, 1'b0);
        tick(); check_a("A.e5", 2'b10, 4'hC, 1'b0, 1'b0);
        en_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_a($sformatf("A.off[%0d]", k), 2'b10, 4'hF, 1'b0, 1'b0);
        end
        en_a = 1'b1;
        tick(); check_a("A.re1", 2'b10, 4'hC, 1'b0, 1'b0);
        tick(); check_a("A.re2", 2'b10, 4'hC, 1'b1, 1'b0);
        tick(); check_a("A.re3", 2'b11, 4'h3, 1'b0, 1'b0);

        // Restart during the channel-3 dwell, then a mid-dwell data change.
        rs_a = 1'b1;
        tick(); check_a("A.rs", 2'b00, 4'hA, 1'b0, 1'b0);
        rs_a = 1'b0;
        tick(); check_a("A.rs1", 2'b00, 4'hA, 1'b0, 1'b0);
        c0_a = 4'h6;
        tick(); check_a("A.rs2", 2'b00, 4'h6, 1'b1, 1'b0);
        c0_a = 4'hA;
        tick(); check_a("A.rs3", 2'b01, 4'h5, 1'b0, 1'b0);

        // Asynchronous reset in the middle of the channel-1 dwell.
        #3 rst_a = 1'b1;
        #1 check_a("A.arst", 2'b00, 4'hF, 1'b0, 1'b0);
        #1 rst_a = 1'b0;
        tick(); check_a("A.ar1", 2'b00, 4'hA, 1'b0, 1'b0);
        tick(); check_a("A.ar2", 2'b00, 4'hA, 1'b1, 1'b0);
        tick(); check_a("A.ar3", 2'b01, 4'h5, 1'b0, 1'b0);
        en_a = 1'b0;

        // DWELL=1: advance every cycle, oValid constant.
        en_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("B[%0d].s", k), 32'({s1_b, s0_b}), 32'(k % 4));
            check($sformatf("B[%0d].z", k), 32'(z_b), 32'(k % 2));
            check($sformatf("B[%0d].v", k), 32'(v_b), 32'h1);
            check($sformatf("B[%0d].f", k), 32'(f_b), 32'(k % 4 == 3));
        end
        en_b = 1'b0;

        // Loopback through the de-selector, DWELL=3.
        for (int j = 0; j < 4; j++)
            check($sformatf("C.idle0.o%0d", j), 32'(desel(j, {s1_c, s0_c}, z_c)), 32'h1);
        en_c = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("C[%0d].s", k), 32'({s1_c, s0_c}), 32'((k / 3) % 4));
            check($sformatf("C[%0d].v", k), 32'(v_c), 32'(k % 3 == 2));
            for (int j = 0; j < 4; j++)
                check($sformatf("C[%0d].o%0d", k, j), 32'(desel(j, {s1_c, s0_c}, z_c)),
                      32'((j == (k / 3) % 4) ? tab_c[j] : 1'b1));
        end
        en_c = 1'b0;
        tick();
        check("C.off.s", 32'({s1_c, s0_c}), 32'h3);
        for (int j = 0; j < 4; j++)
            check($sformatf("C.off.o%0d", j), 32'(desel(j, {s1_c, s0_c}, z_c)), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sel41_scanner.md
# sel41_scanner

Time-division 4-to-1 selector: scans four input channels round-robin, holding each for a programmable dwell, and emits the selected data together with its 2-bit channel code (iS1/iS0 style). It is the transmit end of the 1-to-4 de-selector path. Its oS1/oS0/oZ outputs wire directly to a de-selector's select and data inputs, so one shared line carries four channels. Idle and disabled output level is all-ones, the same inactive level the de-selector drives on unselected outputs.

## Interface
- W, 1, width of each data channel and of oZ (>=1)
- DWELL, 4, cycles each channel stays selected (>=1)
- iClk  input  1  clock; all state changes on rising edge
- iRst  input  1  reset, asynchronous, active-high
- iEn  input  1  scan enable; low forces idle output and freezes the channel
- iRestart  input  1  synchronous restart to channel 0, dwell count 0
- iC0..iC3  input  W each  channel data
- oS1, oS0  output  1 each  registered channel code of the current oZ
- oZ  output  W  registered selected data; all-ones when idle
- oValid  output  1  one-cycle pulse on the last dwell cycle of a channel
- oFrame  output  1  one-cycle pulse coincident with oValid for channel 3

## Operation
- Internal state:
  - sel: 2 bits, scan pointer.
  - dcnt: max(1, clog2(DWELL)) bits, dwell counter.
  - state: IDLE or SCAN.
- Reset (async): sel=0, dcnt=0, state=IDLE, oS1=oS0=0, oZ=all-ones, oValid=0, oFrame=0.
- IDLE -> SCAN when iEn=1. SCAN -> IDLE when iEn=0. state always equals the previous cycle's iEn.
- Each edge with iEn=1 and iRestart=0:
  - Output registers load oS={sel}, oZ=iC[sel].
  - oValid = (dcnt==DWELL-1); oFrame = oValid && sel==3.
  - If dcnt==DWELL-1: dcnt<=0 and sel<=sel+1 (wrap 3->0). Otherwise dcnt<=dcnt+1.
- Each edge with iEn=0:
  - oZ<=all-ones, oValid<=0, oFrame<=0, dcnt<=0.
  - sel and oS hold.
  - Re-enabling resumes at the held channel with a full dwell.
- iRestart=1 has priority over advancement:
  - sel<=0, dcnt<=0, oValid<=0, oFrame<=0.
  - oS<=00. oZ<=iC0 if iEn=1, else all-ones.
  - The next edge begins a full dwell on channel 0.
- DWELL=1: channel advances every cycle and oValid is constantly high while scanning.
- Inputs are sampled combinationally through the mux at the edge. No input registering; source channels are synchronous to iClk.

## Timing
- Latency: one cycle from sel/iC to oS/oZ. oS1, oS0, oZ, oValid, oFrame are all registered and mutually aligned.
- A full frame is 4*DWELL cycles. oFrame occurs once per frame.
- oZ follows input changes within a dwell, with one-cycle latency. No per-channel latching.
- Reset asserted mid-dwell clears everything immediately (async). Deassertion takes effect at the next edge.
- iEn toggled mid-dwell discards the partial dwell. No oValid is produced for it.

## Structure
- Shared package holds:
  - the channel code constants CH0..CH3 = 2'b00..2'b11;
  - the state encoding IDLE/SCAN;
  - the IDLE_LEVEL rule (all-ones of width W).
- The de-selector uses the same channel code constants.
- One natural sub-module: sel41_mux (combinational 4:1, width W, select 2-bit). The scanner instantiates it and adds counters and output registers.

## Test plan
- W=4, DWELL=2, iC0=A, iC1=5, iC2=C, iC3=3; release reset, iEn=1:
  - oS/oZ sequence 00/A, 00/A, 01/5, 01/5, 10/C, 10/C, 11/3, 11/3, repeating.
  - oValid high on every 2nd output cycle.
  - oFrame only on the second 11/3 cycle.
- Same setup, drop iEn for 3 cycles during the first channel-2 cycle:
  - oZ=F while low, oS holds 10, no oValid.
  - After re-enable: two cycles of 10/C, then 11/3.
- Assert iRestart during the channel-3 dwell with iEn=1:
  - Next output 00/A with oValid=0, oFrame=0.
  - Then a full 2-cycle dwell on channel 0.
- DWELL=1, W=1, iC0..3=0,1,0,1:
  - oZ toggles 0,1,0,1 with oS counting 00,01,10,11.
  - oValid constantly 1; oFrame every 4th cycle.
- Assert iRst asynchronously mid-dwell on channel 1:
  - Outputs go immediately to oS=00, oZ=all-ones, oValid=0.
  - After release with iEn=1, scanning restarts at channel 0.
- Loopback into a de-selector, W=1, DWELL=3:
  - Each de-selector output equals its channel's input during that channel's slot.
  - All de-selector outputs are 1 while oZ is idle.
